// File: rtl/oled_text_renderer.sv
// Text renderer for a 96x64 RGB565 OLED: turns a short ASCII string into
// window-address commands plus per-glyph-row pixel bytes for the SPI transmitter.
module oled_text_renderer #(
  parameter int NCHARS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NCHARS-1:0]   req_text,
  input  logic [6:0]            req_col,
  input  logic [5:0]            req_row,
  input  logic [15:0]           req_fg,
  input  logic [15:0]           req_bg,
  output logic [10:0]           font_addr,
  input  logic [7:0]            font_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_dc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(NCHARS + 1);

  // CHECK and NEXT_CHAR are resolved in the cycle that would enter them, so
  // characters stream back to back with no bubble; the register never holds them.
  typedef enum logic [2:0] {
    IDLE, CHECK, CMD, FETCH, LATCH, PIX, NEXT_CHAR, FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [NCHARS-1:0][7:0]   text_q, text_d;
  logic [7:0]               col_q, col_d;
  logic [5:0]               row_q, row_d;
  logic [15:0]              fg_q, fg_d, bg_q, bg_d;
  logic [7:0]               glyph_q, glyph_d;
  logic [CW-1:0]            chr_q, chr_d;
  logic [2:0]               grow_q, grow_d;
  logic [3:0]               bidx_q, bidx_d;
  logic [10:0]              fa_q, fa_d;
  logic                     vld_q, vld_d;
  logic [7:0]               data_q, data_d;
  logic                     dc_q, dc_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     rdy_q, rdy_d;
  logic                     busy_q, busy_d;

  logic                     xfer;
  logic [7:0]               cur_char;
  logic [7:0]               ncol;
  logic [3:0]               b_nx;
  logic                     more;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [7:0] c,
                                          input logic [5:0] r);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h15;
      3'd1:    b = c;
      3'd2:    b = c + 8'd7;
      3'd3:    b = 8'h75;
      3'd4:    b = {2'b00, r};
      default: b = {2'b00, r} + 8'd7;
    endcase
    return b;
  endfunction

  // Byte idx of a glyph row: pixel idx[3:1], high byte first.
  function automatic logic [7:0] pix_byte(input logic [7:0] g, input logic [3:0] idx,
                                          input logic [15:0] fg, input logic [15:0] bg);
    logic [15:0] c;
    c = g[idx[3:1]] ? fg : bg;
    return idx[0] ? c[7:0] : c[15:8];
  endfunction

  always_comb begin
    cur_char = 8'h00;
    for (int k = 0; k < NCHARS; k++)
      if (chr_q == CW'(k)) cur_char = text_q[k];
  end

  assign xfer = vld_q && tx_ready;
  assign b_nx = bidx_q + 4'd1;
  assign ncol = col_q + 8'd8;
  assign more = (int'(chr_q) + 1 < NCHARS) && (ncol <= 8'd88);

  always_comb begin
    state_d = state_q;
    text_d  = text_q;
    col_d   = col_q;
    row_d   = row_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    glyph_d = glyph_q;
    chr_d   = chr_q;
    grow_d  = grow_q;
    bidx_d  = bidx_q;
    fa_d    = fa_q;
    vld_d   = vld_q;
    data_d  = data_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          text_d = req_text;
          col_d  = {1'b0, req_col};
          row_d  = req_row;
          fg_d   = req_fg;
          bg_d   = req_bg;
          chr_d  = '0;
          grow_d = 3'd0;
          bidx_d = 4'd0;
          if (req_col > 7'd88 || req_row > 6'd56) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else begin
            state_d = CMD;
            vld_d   = 1'b1;
            data_d  = 8'h15;
            dc_d    = 1'b0;
          end
        end
      end
      CMD: begin
        if (xfer) begin
          if (bidx_q == 4'd5) begin
            state_d = FETCH;
            vld_d   = 1'b0;
            fa_d    = {cur_char, 3'd0};
          end else begin
            bidx_d = b_nx;
            data_d = cmd_byte(b_nx[2:0], col_q, row_q);
          end
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // First pixel byte comes straight off the ROM so PIX starts with data ready.
        glyph_d = font_data;
        state_d = PIX;
        vld_d   = 1'b1;
        dc_d    = 1'b1;
        bidx_d  = 4'd0;
        data_d  = pix_byte(font_data, 4'd0, fg_q, bg_q);
      end
      PIX: begin
        if (xfer) begin
          if (bidx_q == 4'd15) begin
            vld_d = 1'b0;
            if (grow_q != 3'd7) begin
              grow_d  = grow_q + 3'd1;
              state_d = FETCH;
              fa_d    = {cur_char, grow_q + 3'd1};
            end else if (more) begin
              chr_d   = chr_q + CW'(1);
              col_d   = ncol;
              grow_d  = 3'd0;
              bidx_d  = 4'd0;
              state_d = CMD;
              vld_d   = 1'b1;
              data_d  = 8'h15;
              dc_d    = 1'b0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bidx_d = b_nx;
            data_d = pix_byte(glyph_q, b_nx, fg_q, bg_q);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      text_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      glyph_q <= '0;
      chr_q   <= '0;
      grow_q  <= '0;
      bidx_q  <= '0;
      fa_q    <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      text_q  <= text_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      glyph_q <= glyph_d;
      chr_q   <= chr_d;
      grow_q  <= grow_d;
      bidx_q  <= bidx_d;
      fa_q    <= fa_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = rdy_q;
  assign font_addr = fa_q;
  assign tx_valid  = vld_q;
  assign tx_data   = data_q;
  assign tx_dc     = dc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_oled_text_renderer.sv
// Directed bench for oled_text_renderer: registered font ROM model, byte
// stream capture, and hand-computed expectations for each scenario.
module tb_oled_text_renderer;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [23:0] req_text;
  logic [6:0]  req_col;
  logic [5:0]  req_row;
  logic [15:0] req_fg, req_bg;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic        tx_valid, tx_ready, tx_dc, busy, done, err;
  logic [7:0]  tx_data;
  logic        rnd_en = 1'b0, rnd_bit = 1'b1, rdy_fixed = 1'b1;

  always #5 clk = ~clk;
  assign tx_ready = rnd_en ? rnd_bit : rdy_fixed;

  oled_text_renderer #(.NCHARS(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_text(req_text), .req_col(req_col), .req_row(req_row),
    .req_fg(req_fg), .req_bg(req_bg), .font_addr(font_addr), .font_data(font_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dc(tx_dc),
    .busy(busy), .done(done), .err(err));

  function automatic logic [7:0] glyph(input logic [7:0] ch, input logic [2:0] r);
    logic [63:0] g;
    case (ch)
      8'h47:   g = 64'h007C6673_0303663C; // G
      8'h4F:   g = 64'h001C3663_6363361C; // O
      8'h45:   g = 64'h007F4616_1E16467F; // E
      8'h52:   g = 64'h00676636_3E66663F; // R
      8'h53:   g = 64'h001E3338_0E07331E; // S
      default: g = 64'h0;
    endcase
    return g[8*r +: 8];
  endfunction

  always @(posedge clk) font_data <= glyph(font_addr[10:3], font_addr[2:0]);
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: transfers, stall stability, done/err pulses, fetch addresses.
  logic [8:0]  xq[$];
  logic [10:0] faq[$];
  int   last_x = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int   vld_cnt = 0, stab_bad = 0;
  logic busy_at_done = 1'b0, rdy_at_done = 1'b0;
  logic pv = 1'b0, pstall = 1'b0, prst = 1'b0, pdc = 1'b0;
  logic [7:0]  pdata = 8'h00;
  logic [10:0] fa1 = '0, fa2 = '0;

  always @(negedge clk) begin
    if (pstall && !prst && (!tx_valid || tx_data !== pdata || tx_dc !== pdc)) stab_bad++;
    if (tx_valid) vld_cnt++;
    if (tx_valid && tx_ready) begin
      xq.push_back({tx_dc, tx_data});
      last_x = cyc;
    end
    if (tx_valid && tx_dc && !pv) faq.push_back(fa2);
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
      rdy_at_done  = req_ready;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    pstall = tx_valid && !tx_ready;
    pdata  = tx_data;
    pdc    = tx_dc;
    pv     = tx_valid;
    prst   = rst;
    fa2    = fa1;
    fa1    = font_addr;
  end

  int n_cmp = 0, n_bad = 0;
  logic [8:0] eq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [23:0] t, input logic [6:0] c, input logic [5:0] r,
                      input logic [15:0] fg, input logic [15:0] bg, output int c0);
    int k = 0;
    @(posedge clk); #1;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_text = t; req_col = c; req_row = r; req_fg = fg; req_bg = bg;
    req_valid = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int cap);
    int k = 0;
    while (done_cnt == d0 && k < cap) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic build_exp(input logic [23:0] t, input logic [6:0] c, input logic [5:0] r,
                           input logic [15:0] fg, input logic [15:0] bg);
    logic [7:0]  cc, ch, g;
    logic [15:0] px;
    eq.delete();
    for (int i = 0; i < 3; i++) begin
      cc = {1'b0, c} + 8'(8 * i);
      if (cc > 8'd88) break;
      ch = t[8*i +: 8];
      eq.push_back({1'b0, 8'h15}); eq.push_back({1'b0, cc}); eq.push_back({1'b0, cc + 8'd7});
      eq.push_back({1'b0, 8'h75}); eq.push_back({1'b0, 2'b00, r});
      eq.push_back({1'b0, {2'b00, r} + 8'd7});
      for (int gr = 0; gr < 8; gr++) begin
        g = glyph(ch, 3'(gr));
        for (int x = 0; x < 8; x++) begin
          px = g[x] ? fg : bg;
          eq.push_back({1'b1, px[15:8]});
          eq.push_back({1'b1, px[7:0]});
        end
      end
    end
  endtask

  task automatic cmp_stream(input string tag, input int base);
    int mism = 0;
    for (int i = 0; i < eq.size(); i++)
      if (base + i >= xq.size() || xq[base+i] !== eq[i]) mism++;
    chk({tag, "_bytes"}, 32'(mism), 32'd0);
    chk({tag, "_count"}, 32'(xq.size() - base), 32'(eq.size()));
  endtask

  logic [7:0] go_cmd[6]  = '{8'h15, 8'h00, 8'h07, 8'h75, 8'h00, 8'h07};
  logic [7:0] g_row0[16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] e_cmd[6]   = '{8'h15, 8'h50, 8'h57, 8'h75, 8'h0A, 8'h11};
  logic [7:0] r_cmd[6]   = '{8'h15, 8'h58, 8'h5F, 8'h75, 8'h0A, 8'h11};

  initial begin
    int c0, base, d0, e0, v0, s0, fb, mism, k;
    rst = 1'b1; req_valid = 1'b0; req_text = '0; req_col = '0; req_row = '0;
    req_fg = '0; req_bg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // "GO " at (0,0), white on black, tx_ready held high
    base = xq.size(); d0 = done_cnt;
    send(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000, c0);
    wait_done("go_done", d0, 1000);
    for (int i = 0; i < 6; i++)
      chk($sformatf("go_cmd%0d", i), 32'(xq[base+i]), 32'({1'b0, go_cmd[i]}));
    for (int i = 0; i < 16; i++)
      chk($sformatf("g_row0_%0d", i), 32'(xq[base+6+i]), 32'({1'b1, g_row0[i]}));
    build_exp(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000);
    cmp_stream("go", base);
    chk("go_done_cyc", 32'(done_cyc - c0), 32'd451);
    chk("go_last_xfer", 32'(last_x - c0), 32'd450);
    chk("go_busy_at_done", 32'(busy_at_done), 32'd0);
    chk("go_ready_at_done", 32'(rdy_at_done), 32'd1);

    // Same request under random backpressure
    base = xq.size(); d0 = done_cnt; v0 = vld_cnt; s0 = stab_bad;
    rnd_en = 1'b1;
    send(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000, c0);
    wait_done("rnd_done", d0, 5000);
    rnd_en = 1'b0;
    cmp_stream("rnd", base);
    chk("rnd_stable", 32'(stab_bad - s0), 32'd0);
    chk("rnd_done_after_last", 32'(done_cyc - last_x), 32'd1);
    chk("rnd_done_cyc", 32'(done_cyc - c0), 32'(vld_cnt - v0 + 49));

    // "ERS" at col 80: third char clipped
    base = xq.size(); d0 = done_cnt;
    send(24'h535245, 7'd80, 6'd10, 16'h07E0, 16'h0000, c0);
    wait_done("ers_done", d0, 1000);
    mism = 0;
    for (int i = 0; i < 6; i++) begin
      if (xq[base+i] !== {1'b0, e_cmd[i]}) mism++;
      if (xq[base+134+i] !== {1'b0, r_cmd[i]}) mism++;
    end
    chk("ers_cmds", 32'(mism), 32'd0);
    build_exp(24'h535245, 7'd80, 6'd10, 16'h07E0, 16'h0000);
    cmp_stream("ers", base);
    chk("ers_total", 32'(xq.size() - base), 32'd268);

    // Rejects: row 57, then col 89
    d0 = done_cnt; e0 = err_cnt; v0 = vld_cnt;
    send(24'h204F47, 7'd0, 6'd57, 16'hFFFF, 16'h0000, c0);
    chk("rej_row_err_c1", 32'(err), 32'd1);
    chk("rej_row_ready_c1", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rej_row_ready_c2", 32'(req_ready), 32'd1);
    chk("rej_row_err_c2", 32'(err), 32'd0);
    send(24'h204F47, 7'd89, 6'd0, 16'hFFFF, 16'h0000, c0);
    chk("rej_col_err_c1", 32'(err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("rej_err_cnt", 32'(err_cnt - e0), 32'd2);
    chk("rej_err_cyc", 32'(err_cyc - c0), 32'd1);
    chk("rej_no_valid", 32'(vld_cnt - v0), 32'd0);
    chk("rej_no_done", 32'(done_cnt - d0), 32'd0);

    // Spaces at col 88: one blank glyph in background red
    base = xq.size(); d0 = done_cnt; fb = faq.size();
    send(24'h202020, 7'd88, 6'd0, 16'h001F, 16'hF800, c0);
    wait_done("spc_done", d0, 1000);
    chk("spc_px0_hi", 32'(xq[base+6]), 32'h1F8);
    chk("spc_px0_lo", 32'(xq[base+7]), 32'h100);
    build_exp(24'h202020, 7'd88, 6'd0, 16'h001F, 16'hF800);
    cmp_stream("spc", base);
    mism = 0;
    for (int r = 0; r < 8; r++)
      if (fb + r >= faq.size() || faq[fb+r] !== {8'h20, 3'(r)}) mism++;
    chk("spc_font_addr", 32'(mism), 32'd0);
    chk("spc_fetches", 32'(faq.size() - fb), 32'd8);

    // Reset mid-stream while stalled
    base = xq.size(); d0 = done_cnt; k = 0;
    send(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000, c0);
    while (xq.size() - base < 40 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_40", 32'(xq.size() - base >= 40), 32'd1);
    @(posedge clk); #1;
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_stalled_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_txv_dc_data", 32'({tx_valid, tx_dc, tx_data}), 32'd0);
    chk("mid_rst_busy_ready", 32'({busy, req_ready}), 32'd0);
    chk("mid_rst_done_err", 32'({done, err}), 32'd0);
    chk("mid_rst_font_addr", 32'(font_addr), 32'd0);
    rst = 1'b0;
    rdy_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    base = xq.size(); d0 = done_cnt;
    send(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000, c0);
    wait_done("post_rst_done", d0, 1000);
    chk("post_rst_first", 32'(xq[base]), 32'h015);
    build_exp(24'h204F47, 7'd0, 6'd0, 16'hFFFF, 16'h0000);
    cmp_stream("post_rst", base);
    chk("stall_stability_total", 32'(stab_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
